// File: rtl/program_loader.sv
// Byte-stream loader for the 10-bit instruction memory: length header, then
// two bytes per instruction, written to consecutive addresses from 0.
module program_loader #(
    parameter int ADDR_WIDTH  = 8,
    parameter int INSTR_WIDTH = 10
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [7:0]             byte_in,
    input  logic                   byte_valid,
    output logic                   byte_ready,
    output logic                   imem_we,
    output logic [ADDR_WIDTH-1:0]  imem_addr,
    output logic [INSTR_WIDTH-1:0] imem_wdata,
    output logic                   cpu_hold,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic [ADDR_WIDTH:0]    word_count
);

    localparam int LW = ADDR_WIDTH + 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEN   = 3'd1,
        S_HI    = 3'd2,
        S_LO    = 3'd3,
        S_WRITE = 3'd4,
        S_DONE  = 3'd5,
        S_ERROR = 3'd6
    } state_t;

    state_t                 state_r;
    state_t                 state_s;
    logic                   clear_s;
    logic                   byte_ready_s;
    logic                   accept_s;
    logic [LW-1:0]          wc_r;
    logic [LW-1:0]          wc_inc_s;
    logic [LW-1:0]          len_r;
    logic [1:0]             hi_r;
    logic [INSTR_WIDTH-1:0] wdata_r;
    logic                   imem_we_r;
    logic                   cpu_hold_r;
    logic                   busy_r;
    logic                   done_r;
    logic                   error_r;

    assign accept_s = byte_valid & byte_ready_s;
    assign wc_inc_s = wc_r + LW'(1'b1);

    // Next-state decode; counters are cleared whenever a start is honoured.
    always_comb begin
        state_s      = state_r;
        clear_s      = 1'b0;
        byte_ready_s = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    state_s = S_LEN;
                    clear_s = 1'b1;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_LEN: begin
                byte_ready_s = 1'b1;
                if (accept_s) begin
                    state_s = S_HI;
                end else begin
                    state_s = S_LEN;
                end
            end
            S_HI: begin
                byte_ready_s = 1'b1;
                if (accept_s) begin
                    if (byte_in[7:2] == 6'd0) begin
                        state_s = S_LO;
                    end else begin
                        state_s = S_ERROR;
                    end
                end else begin
                    state_s = S_HI;
                end
            end
            S_LO: begin
                byte_ready_s = 1'b1;
                if (accept_s) begin
                    state_s = S_WRITE;
                end else begin
                    state_s = S_LO;
                end
            end
            S_WRITE: begin
                if (wc_inc_s == len_r) begin
                    state_s = S_DONE;
                end else begin
                    state_s = S_HI;
                end
            end
            S_DONE, S_ERROR: begin
                if (start) begin
                    state_s = S_LEN;
                    clear_s = 1'b1;
                end else if (state_r == S_DONE) begin
                    state_s = S_IDLE;
                end else begin
                    state_s = S_ERROR;
                end
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath and status flags; flags decode the next state so they are glitch-free registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wc_r       <= {LW{1'b0}};
            len_r      <= {LW{1'b0}};
            hi_r       <= 2'd0;
            wdata_r    <= {INSTR_WIDTH{1'b0}};
            imem_we_r  <= 1'b0;
            cpu_hold_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            error_r    <= 1'b0;
        end else begin
            if (clear_s) begin
                wc_r <= {LW{1'b0}};
            end else if (state_r == S_WRITE) begin
                wc_r <= wc_inc_s;
            end
            if (state_r == S_LEN && accept_s) begin
                len_r <= LW'(byte_in) + LW'(1'b1);
            end
            if (state_r == S_HI && accept_s) begin
                hi_r <= byte_in[1:0];
            end
            if (state_r == S_LO && accept_s) begin
                wdata_r <= INSTR_WIDTH'({hi_r, byte_in});
            end
            imem_we_r  <= (state_s == S_WRITE);
            done_r     <= (state_s == S_DONE);
            error_r    <= (state_s == S_ERROR);
            busy_r     <= (state_s == S_LEN) || (state_s == S_HI) ||
                          (state_s == S_LO)  || (state_s == S_WRITE);
            cpu_hold_r <= (state_s == S_LEN) || (state_s == S_HI) ||
                          (state_s == S_LO)  || (state_s == S_WRITE) ||
                          (state_s == S_ERROR);
        end
    end

    assign byte_ready = byte_ready_s;
    assign imem_we    = imem_we_r;
    assign imem_addr  = wc_r[ADDR_WIDTH-1:0];
    assign imem_wdata = wdata_r;
    assign cpu_hold   = cpu_hold_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign error      = error_r;
    assign word_count = wc_r;

endmodule

// File: tb/tb_program_loader.sv
// Randomised bench for program_loader: a driver predicts each write and done
// cycle from the handshake it performs, and one compare process checks them.
module tb_program_loader;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] byte_in;
    logic       byte_valid;
    logic       byte_ready;
    logic       imem_we;
    logic [7:0] imem_addr;
    logic [9:0] imem_wdata;
    logic       cpu_hold;
    logic       busy;
    logic       done;
    logic       error;
    logic [8:0] word_count;

    program_loader dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_hold   (cpu_hold),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    typedef struct { int cyc; logic [7:0] addr; logic [9:0] data; } wr_t;
    typedef struct { int cyc; int cnt; } dn_t;
    wr_t wr_q[$];
    dn_t dn_q[$];
    logic [9:0] words [256];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Compare process: every cycle, writes and done must occur exactly when predicted.
    always begin
        @(posedge clk);
        #2;
        if (wr_q.size() > 0 && wr_q[0].cyc == cyc) begin
            chk("we", 32'(imem_we), 32'd1);
            chk("addr", 32'(imem_addr), 32'(wr_q[0].addr));
            chk("wdata", 32'(imem_wdata), 32'(wr_q[0].data));
            chk("wc_at_write", 32'(word_count), 32'(wr_q[0].addr));
            void'(wr_q.pop_front());
        end else begin
            chk("spurious_we", 32'(imem_we), 32'd0);
        end
        if (dn_q.size() > 0 && dn_q[0].cyc == cyc) begin
            chk("done", 32'(done), 32'd1);
            chk("done_count", 32'(word_count), 32'(dn_q[0].cnt));
            void'(dn_q.pop_front());
        end else begin
            chk("spurious_done", 32'(done), 32'd0);
        end
        chk("hold_vs_state", 32'(cpu_hold), 32'(busy | error));
        chk("ready_vs_state", 32'(byte_ready), 32'(busy & ~imem_we));
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Offer one byte after 'stall' idle cycles; a LO byte books its write (and done if last).
    task automatic send_byte(input logic [7:0] b, input int stall, input bit is_lo,
                             input logic [7:0] addr, input logic [9:0] data,
                             input bit last, input int cnt);
        bit  ok;
        wr_t w;
        dn_t d;
        ok = 1'b0;
        byte_valid = 1'b0;
        repeat (stall) @(negedge clk);
        byte_in    = b;
        byte_valid = 1'b1;
        for (int t = 0; t < 20; t++) begin
            if (byte_ready) begin
                if (is_lo) begin
                    w.cyc = cyc + 1; w.addr = addr; w.data = data;
                    wr_q.push_back(w);
                    if (last) begin
                        d.cyc = cyc + 2; d.cnt = cnt;
                        dn_q.push_back(d);
                    end
                end
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (ok) begin
            @(negedge clk);
        end else begin
            chk("accept_timeout", 32'd0, 32'd1);
        end
        byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [9:0] data, input int stall, input int idx, input int n);
        send_byte({6'd0, data[9:8]}, stall, 1'b0, 8'd0, 10'd0, 1'b0, 0);
        send_byte(data[7:0], stall, 1'b1, 8'(idx), data, (idx == n - 1), n);
    endtask

    // Full load of words[0..n-1]; optionally pulses start while waiting for the first HI byte.
    task automatic run_load(input int n, input int smin, input int smax, input bit poke_start);
        pulse_start();
        send_byte(8'(n - 1), $urandom_range(smax, smin), 1'b0, 8'd0, 10'd0, 1'b0, 0);
        if (poke_start) begin
            pulse_start();
            chk("start_in_hi_busy", 32'(busy), 32'd1);
            chk("start_in_hi_ready", 32'(byte_ready), 32'd1);
        end
        for (int i = 0; i < n; i++) begin
            send_word(words[i], $urandom_range(smax, smin), i, n);
        end
        repeat (4) @(negedge clk);
        chk("writes_pending", 32'(wr_q.size()), 32'd0);
        chk("done_pending", 32'(dn_q.size()), 32'd0);
        chk("final_wc", 32'(word_count), 32'(n));
        chk("idle_hold", 32'(cpu_hold), 32'd0);
    endtask

    initial begin
        int n;
        reset = 1'b1; start = 1'b0; byte_in = 8'd0; byte_valid = 1'b0;
        #12;
        chk("rst_hold", 32'(cpu_hold), 32'd0);
        chk("rst_ready", 32'(byte_ready), 32'd0);
        chk("rst_wc", 32'(word_count), 32'd0);
        chk("rst_wdata", 32'(imem_wdata), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Single word from literal bytes 00, 02, A5 -> addr 0, data 0x2A5.
        pulse_start();
        chk("hold_after_start", 32'(cpu_hold), 32'd1);
        send_byte(8'h00, 0, 1'b0, 8'd0, 10'd0, 1'b0, 0);
        send_byte(8'h02, 0, 1'b0, 8'd0, 10'd0, 1'b0, 0);
        chk("hold_in_lo", 32'(cpu_hold), 32'd1);
        send_byte(8'hA5, 0, 1'b1, 8'h00, 10'h2A5, 1'b1, 1);
        repeat (3) @(negedge clk);
        chk("single_pending", 32'(wr_q.size() + dn_q.size()), 32'd0);
        chk("single_wc", 32'(word_count), 32'd1);

        // Three words, two idle cycles between every byte.
        words[0] = 10'h3FF; words[1] = 10'h000; words[2] = 10'h155;
        run_load(3, 2, 2, 1'b0);

        // Bad high byte drives ERROR; then a start recovers.
        pulse_start();
        send_byte(8'h01, 0, 1'b0, 8'd0, 10'd0, 1'b0, 0);
        send_byte(8'h04, 0, 1'b0, 8'd0, 10'd0, 1'b0, 0);
        chk("err_flag", 32'(error), 32'd1);
        chk("err_hold", 32'(cpu_hold), 32'd1);
        chk("err_ready", 32'(byte_ready), 32'd0);
        chk("err_busy", 32'(busy), 32'd0);
        byte_in = 8'h00; byte_valid = 1'b1;
        repeat (3) @(negedge clk);
        byte_valid = 1'b0;
        chk("err_sticky", 32'(error), 32'd1);
        words[0] = 10'($urandom);
        run_load(1, 0, 0, 1'b0);
        chk("err_cleared", 32'(error), 32'd0);

        // Start pulsed while in HI must be ignored.
        words[0] = 10'h155; words[1] = 10'h0AA; words[2] = 10'h3C3;
        run_load(3, 0, 1, 1'b1);

        // Full memory: word i = i.
        for (int i = 0; i < 256; i++) words[i] = 10'(i);
        run_load(256, 0, 0, 1'b0);

        // Random loads.
        for (int r = 0; r < 6; r++) begin
            n = $urandom_range(24, 1);
            for (int i = 0; i < n; i++) words[i] = 10'($urandom);
            run_load(n, 0, 2, (r == 3));
        end

        // Asynchronous reset while in LO of the second word.
        words[0] = 10'h12C;
        pulse_start();
        send_byte(8'h01, 0, 1'b0, 8'd0, 10'd0, 1'b0, 0);
        send_word(words[0], 0, 0, 2);
        send_byte(8'h01, 0, 1'b0, 8'd0, 10'd0, 1'b0, 0);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        #3 reset = 1'b1;
        #1;
        chk("arst_we", 32'(imem_we), 32'd0);
        chk("arst_hold", 32'(cpu_hold), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_ready", 32'(byte_ready), 32'd0);
        chk("arst_addr", 32'(imem_addr), 32'd0);
        chk("arst_wdata", 32'(imem_wdata), 32'd0);
        chk("arst_wc", 32'(word_count), 32'd0);
        chk("arst_flags", 32'({done, error}), 32'd0);
        @(negedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        byte_in = 8'h33; byte_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("post_rst_ready", 32'(byte_ready), 32'd0);
            chk("post_rst_busy", 32'(busy), 32'd0);
            @(negedge clk);
        end
        byte_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("final_queues", 32'(wr_q.size() + dn_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
Byte-stream writer for the 10-bit instruction memory. It is the write-side counterpart of the CPU's instruction fetch path. It accepts a length header and then two bytes per instruction over a valid/ready handshake, and packs each pair into a 10-bit word. It writes each word to consecutive instruction-memory addresses starting at 0, and holds the CPU in reset through cpu_hold until the load completes.

Parameters:
ADDR_WIDTH, 8, instruction-memory address width; matches the PC output width.
INSTR_WIDTH, 10, instruction width. Fixed at 10 by the packing rule.

Ports:
clk  in  1  system clock; all state changes on the rising edge
reset  in  1  asynchronous, active-high; forces the IDLE state
start  in  1  one-cycle pulse that begins a load; honoured only in IDLE, DONE or ERROR
byte_in  in  8  incoming stream byte
byte_valid  in  1  byte_in is valid this cycle
byte_ready  out  1  loader accepts a byte this cycle
imem_we  out  1  instruction-memory write strobe, one cycle per word
imem_addr  out  ADDR_WIDTH  write address
imem_wdata  out  INSTR_WIDTH  write data
cpu_hold  out  1  OR this into reset_CPU; high while a load is in progress or errored
busy  out  1  high in states LEN, HI, LO and WRITE
done  out  1  one-cycle pulse when the last word is written
error  out  1  high while in the ERROR state
word_count  out  ADDR_WIDTH+1  number of words written in the current load

Behaviour:
- Reset (asynchronous):
  - state goes to IDLE.
  - byte_ready, imem_we, cpu_hold, busy, done and error all go to 0.
  - imem_addr, imem_wdata, word_count and the internal length/high-byte registers go to 0.
  - Reset mid-load abandons the load; words already written are not undone.
- Handshake:
  - A byte is accepted on a rising edge where byte_valid and byte_ready are both 1.
  - byte_ready is 1 only in LEN, HI and LO, combinationally from state.
  - byte_valid while byte_ready is 0 is ignored; the byte is not consumed.
- IDLE:
  - On start, clear word_count and the address counter to 0, set cpu_hold to 1 and go to LEN.
  - Otherwise stay in IDLE.
- LEN:
  - On accept, store len = byte_in + 1 (range 1..256, 9 bits wide) and go to HI.
- HI:
  - On accept with byte_in[7:2] equal to 0, store byte_in[1:0] and go to LO.
  - On accept with byte_in[7:2] nonzero, go to ERROR.
- LO:
  - On accept, latch imem_wdata = {hi[1:0], byte_in} and go to WRITE.
- WRITE (exactly one cycle):
  - imem_we is 1, imem_addr holds the current address and imem_wdata is stable.
  - On exit, word_count increments and the address counter increments.
  - If the incremented word_count equals len, go to DONE; otherwise go to HI.
- DONE:
  - done is 1 for this one cycle and cpu_hold is 0.
  - Next state is IDLE; if start is 1 in this cycle, go to LEN instead.
  - word_count retains its value until the next start.
- ERROR:
  - error is 1 and cpu_hold stays 1 so the CPU does not run a partial program.
  - start restarts the load by going to LEN with counters cleared; reset also exits.
- start in LEN, HI, LO or WRITE is ignored.
- Address arithmetic: imem_addr = word_count[ADDR_WIDTH-1:0].
  - When len = 256, the last write goes to address 255. No wrap occurs within a load.
- Latency: imem_we rises on the cycle after the LO byte is accepted.
  - Peak throughput is 1 word per 3 cycles: HI accept, LO accept, WRITE.
- done and imem_we are never 1 in the same cycle.
- cpu_hold is registered, with no glitches: 1 in LEN, HI, LO, WRITE and ERROR; 0 in IDLE and DONE.

Test Plan:
- Single word:
  - Stimulus: start, then bytes 0x00, 0x02, 0xA5, each with valid held high.
  - Required: one imem_we pulse with addr = 0 and wdata = 0x2A5; done pulses on the next cycle; word_count = 1; cpu_hold is 1 from the cycle after start to the cycle before done.
- Three words with stalls:
  - Stimulus: header 0x02, then words 0x3FF, 0x000, 0x155, with byte_valid deasserted for 2 cycles between every byte.
  - Required: writes to addresses 0, 1, 2 with exactly those data values; no extra writes; word_count = 3.
- Bad high byte:
  - Stimulus: header 0x01, then HI byte 0x04.
  - Required: state is ERROR with error = 1, cpu_hold = 1, no imem_we pulse, and byte_ready = 0.
  - Follow-up: a start pulse then a valid single-word load recovers; done pulses and error = 0.
- Full memory:
  - Stimulus: header 0xFF, then 256 words where word i = i.
  - Required: the last write is at addr 0xFF with wdata 0x0FF; word_count = 256; done pulses once.
- Reset mid-load:
  - Stimulus: assert reset asynchronously (not clock-aligned) while in LO of the second word.
  - Required: all outputs are 0 immediately; the state is IDLE; a byte presented afterwards with byte_valid = 1 is not accepted.
- Start ignored while busy:
  - Stimulus: pulse start while in HI.
  - Required: the load continues unchanged and the header is not re-read.
